uart_tx_param: RTL and testbench

Parametrised UART transmitter, the next generation of the team's fixed 8E1 transmitter. It has an internal baud divisor, so no separate protocol clock is needed. Data width, parity mode and stop-bit count are set by parameters. A small input FIFO accepts words over a valid/ready handshake. It sits between a byte-producing host (register file or DMA) and the serial `tx` pad, and sends frames back-to-back with no idle gap while the FIFO holds data.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_param_if.sv | 14 +
 rtl/uart_tx_fifo.sv | 54 +++++
 rtl/uart_tx_param.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_param.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter: FSM state
// encoding, parity-mode constants and a frame-length helper.
package uart_pkg;

  // FSM states, kept as plain constants so older tools and netlists see a fixed encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Parity selections for the PARITY_MODE parameter
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Number of serial bit periods in one frame: start, data, optional parity, stops
  function automatic int frame_bits(input int data_bits, input int parity_mode,
                                    input int stop_bits);
    return 1 + data_bits + ((parity_mode != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Host-side valid/ready word interface of the UART transmitter.
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
);

  logic                 s_valid;
  logic [DATA_BITS-1:0] s_data;
  logic                 s_ready;

  // Host drives words, transmitter answers with ready
  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO feeding the UART transmitter. Read data is the
// word at the read pointer, so a pop takes the head word on the same edge.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers and occupancy; reset flushes the FIFO. Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because the count guards every read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: input FIFO, internal baud divisor and a
// start/data/parity/stop FSM driving a registered, idle-high tx line.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  uart_tx_param_if.slave              s_if,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  logic [2:0]           state;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 parity_bit;
  logic                 has_data_q;

  logic [DATA_BITS-1:0] fifo_head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 bit_end;
  logic                 start_ok;
  logic                 pop;

  // Parity of the word being framed; odd is the inverse of even
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
    if (PARITY_MODE == PARITY_ODD) return ~(^d);
    return ^d;
  endfunction

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (s_if.s_valid),
    .push_data (s_if.s_data),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign s_if.s_ready = !fifo_full;
  assign bit_end      = (baud_cnt == BAUD_LAST);
  assign start_ok     = has_data_q && !fifo_empty;
  assign pop = ((state == ST_IDLE) && start_ok) ||
               ((state == ST_STOP) && bit_end && (bit_cnt == STOP_LAST) && start_ok);

  // Registered not-empty flag: a freshly pushed word is seen by the FSM one cycle after it lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) has_data_q <= 1'b0;
    else        has_data_q <= !fifo_empty;
  end

  // Frame sequencer: baud divisor, bit counter, shift register and the registered tx/busy outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          tx       <= 1'b1;
          busy     <= 1'b0;
          if (start_ok) begin
            shift_reg  <= fifo_head;
            parity_bit <= calc_parity(fifo_head);
            state      <= ST_START;
            tx         <= 1'b0;
            busy       <= 1'b1;
          end
        end
        ST_START: begin
          if (bit_end) begin
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            tx        <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            state     <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              if (PARITY_MODE != PARITY_NONE) begin
                tx    <= parity_bit;
                state <= ST_PARITY;
              end else begin
                tx    <= 1'b1;
                state <= ST_STOP;
              end
            end else begin
              bit_cnt   <= bit_cnt + 1'b1;
              tx        <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b1;
            state    <= ST_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              if (start_ok) begin
                shift_reg  <= fifo_head;
                parity_bit <= calc_parity(fifo_head);
                tx         <= 1'b0;
                state      <= ST_START;
              end else begin
                tx    <= 1'b1;
                busy  <= 1'b0;
                state <= ST_IDLE;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          tx       <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: three configurations (8E1, 8O2, 7N1)
// checked cycle by cycle against a frame model built from the protocol rules.
module tb_uart_tx_param;
  import uart_pkg::*;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cycle = 0;
  int   tests = 0;
  int   fails = 0;

  logic       tx_a, busy_a, tx_b, busy_b, tx_c, busy_c;
  logic [2:0] cnt_a, cnt_b, cnt_c;

  logic       cap_tx[$];
  logic       cap_busy[$];
  logic       cap_rdy[$];
  logic [2:0] cap_cnt[$];
  int         fall_cycle;

  uart_tx_param_if #(.DATA_BITS(8)) if_a ();
  uart_tx_param_if #(.DATA_BITS(8)) if_b ();
  uart_tx_param_if #(.DATA_BITS(7)) if_c ();

  uart_tx_param #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .CLKS_PER_BIT(CPB),
                  .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .s_if(if_a.slave), .tx(tx_a), .busy(busy_a), .fifo_count(cnt_a));

  uart_tx_param #(.DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(2), .CLKS_PER_BIT(CPB),
                  .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .s_if(if_b.slave), .tx(tx_b), .busy(busy_b), .fifo_count(cnt_b));

  uart_tx_param #(.DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(1), .CLKS_PER_BIT(CPB),
                  .FIFO_DEPTH(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .s_if(if_c.slave), .tx(tx_c), .busy(busy_c), .fifo_count(cnt_c));

  // Free-running clock and edge counter
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic get_tx(input int sel);
    case (sel) 0: return tx_a; 1: return tx_b; default: return tx_c; endcase
  endfunction
  function automatic logic get_busy(input int sel);
    case (sel) 0: return busy_a; 1: return busy_b; default: return busy_c; endcase
  endfunction
  function automatic logic get_ready(input int sel);
    case (sel) 0: return if_a.s_ready; 1: return if_b.s_ready; default: return if_c.s_ready; endcase
  endfunction
  function automatic logic [2:0] get_cnt(input int sel);
    case (sel) 0: return cnt_a; 1: return cnt_b; default: return cnt_c; endcase
  endfunction

  // Line level of every bit period of one frame, index 0 = start bit
  function automatic logic [15:0] model_frame(input logic [8:0] d, input int db,
                                              input int pm, input int sb);
    logic [15:0] v;
    int ones = 0;
    v = '1;
    v[0] = 1'b0;
    for (int i = 0; i < db; i++) begin
      v[1+i] = d[i];
      ones += int'(d[i]);
    end
    if (pm == PARITY_EVEN) v[1+db] = 1'((ones % 2));
    else if (pm == PARITY_ODD) v[1+db] = 1'(1 - (ones % 2));
    if (sb < 1) v[0] = 1'bx;
    return v;
  endfunction

  task automatic set_valid(input int sel, input logic v, input logic [8:0] w);
    case (sel)
      0: begin if_a.s_valid = v; if_a.s_data = w[7:0]; end
      1: begin if_b.s_valid = v; if_b.s_data = w[7:0]; end
      default: begin if_c.s_valid = v; if_c.s_data = w[6:0]; end
    endcase
  endtask

  // Offer one word and hold it until accepted; pc is the accepting edge
  task automatic push_word(input int sel, input logic [8:0] w, output int pc, output bit ok);
    int guard = 0;
    set_valid(sel, 1'b1, w);
    while (get_ready(sel) !== 1'b1 && guard < 3000) begin
      @(posedge clk); #1; guard++;
    end
    ok = (guard < 3000);
    pc = -1;
    if (ok) begin
      @(posedge clk); #1;
      pc = cycle;
    end
    set_valid(sel, 1'b0, 9'h0);
  endtask

  // Wait for the start bit and record n+1 post-edge samples from it
  task automatic capture(input int sel, input int n, output bit ok);
    int guard = 0;
    cap_tx.delete(); cap_busy.delete(); cap_rdy.delete(); cap_cnt.delete();
    while (get_tx(sel) !== 1'b0 && guard < 3000) begin
      @(posedge clk); #1; guard++;
    end
    ok = (guard < 3000);
    fall_cycle = cycle;
    if (ok) begin
      for (int i = 0; i <= n; i++) begin
        cap_tx.push_back(get_tx(sel));
        cap_busy.push_back(get_busy(sel));
        cap_rdy.push_back(get_ready(sel));
        cap_cnt.push_back(get_cnt(sel));
        if (i < n) begin @(posedge clk); #1; end
      end
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      tests++;
      if (get_tx(s) !== 1'b1 || get_busy(s) !== 1'b0 || get_ready(s) !== 1'b1 || get_cnt(s) !== 3'd0) begin
        fails++;
        $display("[TB] FAIL reset_state dut%0d: tx=%b busy=%b ready=%b count=%0d, need 1 0 1 0",
                 s, get_tx(s), get_busy(s), get_ready(s), get_cnt(s));
      end
    end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_8e1;
    logic [8:0] w;
    logic [15:0] ex;
    int pc, fb, nb;
    bit okp, okc, bad;
    fb = frame_bits(8, PARITY_EVEN, 1);
    for (int t = 0; t < 3; t++) begin
      w = (t == 0) ? 9'h0A5 : 9'($urandom_range(0, 255));
      ex = model_frame(w, 8, PARITY_EVEN, 1);
      push_word(0, w, pc, okp);
      capture(0, fb * CPB, okc);
      tests++;
      if (!okp || !okc) begin
        fails++;
        $display("[TB] FAIL 8e1_timeout word=%h push_ok=%b frame_seen=%b, need 1 1", w, okp, okc);
        continue;
      end
      tests++;
      if (fall_cycle - pc !== 2) begin
        fails++;
        $display("[TB] FAIL 8e1_latency word=%h: start after %0d edges, need 2", w, fall_cycle - pc);
      end
      for (int b = 0; b < fb; b++) begin
        bad = 0;
        for (int c = 0; c < CPB; c++)
          if (cap_tx[b*CPB+c] !== ex[b] || cap_busy[b*CPB+c] !== 1'b1) bad = 1;
        tests++;
        if (bad) begin
          fails++;
          $display("[TB] FAIL 8e1_bit%0d word=%h: tx=%b mid-bit, need %b held %0d cycles with busy",
                   b, w, cap_tx[b*CPB+CPB/2], ex[b], CPB);
        end
      end
      nb = 0;
      foreach (cap_busy[i]) nb += int'(cap_busy[i]);
      tests++;
      if (nb !== fb * CPB) begin
        fails++;
        $display("[TB] FAIL 8e1_busy_len word=%h: %0d cycles, need %0d", w, nb, fb * CPB);
      end
      tests++;
      if (cap_tx[fb*CPB] !== 1'b1 || cap_busy[fb*CPB] !== 1'b0) begin
        fails++;
        $display("[TB] FAIL 8e1_idle word=%h: tx=%b busy=%b, need 1 0",
                 w, cap_tx[fb*CPB], cap_busy[fb*CPB]);
      end
    end
  endtask

  task automatic test_odd_2stop;
    logic [8:0] w;
    logic [15:0] ex;
    int pc, fb;
    bit okp, okc, bad;
    fb = frame_bits(8, PARITY_ODD, 2);
    for (int t = 0; t < 3; t++) begin
      w = (t == 0) ? 9'h000 : 9'($urandom_range(0, 255));
      ex = model_frame(w, 8, PARITY_ODD, 2);
      push_word(1, w, pc, okp);
      capture(1, fb * CPB, okc);
      tests++;
      if (!okp || !okc) begin
        fails++;
        $display("[TB] FAIL odd2_timeout word=%h push_ok=%b frame_seen=%b, need 1 1", w, okp, okc);
        continue;
      end
      if (t == 0) begin
        tests++;
        if (cap_tx[9*CPB+CPB/2] !== 1'b1) begin
          fails++;
          $display("[TB] FAIL odd2_parity_of_zero: parity=%b, need 1", cap_tx[9*CPB+CPB/2]);
        end
      end
      for (int b = 0; b < fb; b++) begin
        bad = 0;
        for (int c = 0; c < CPB; c++)
          if (cap_tx[b*CPB+c] !== ex[b] || cap_busy[b*CPB+c] !== 1'b1) bad = 1;
        tests++;
        if (bad) begin
          fails++;
          $display("[TB] FAIL odd2_bit%0d word=%h: tx=%b mid-bit, need %b held %0d cycles with busy",
                   b, w, cap_tx[b*CPB+CPB/2], ex[b], CPB);
        end
      end
      tests++;
      if (cap_tx[fb*CPB] !== 1'b1 || cap_busy[fb*CPB] !== 1'b0) begin
        fails++;
        $display("[TB] FAIL odd2_idle word=%h: tx=%b busy=%b, need 1 0",
                 w, cap_tx[fb*CPB], cap_busy[fb*CPB]);
      end
    end
  endtask

  task automatic test_7n1;
    logic [8:0] w;
    logic [15:0] ex;
    int pc, fb, nb;
    bit okp, okc, bad;
    fb = frame_bits(7, PARITY_NONE, 1);
    for (int t = 0; t < 3; t++) begin
      w = (t == 0) ? 9'h055 : 9'($urandom_range(0, 127));
      ex = model_frame(w, 7, PARITY_NONE, 1);
      push_word(2, w, pc, okp);
      capture(2, fb * CPB, okc);
      tests++;
      if (!okp || !okc) begin
        fails++;
        $display("[TB] FAIL 7n1_timeout word=%h push_ok=%b frame_seen=%b, need 1 1", w, okp, okc);
        continue;
      end
      for (int b = 0; b < fb; b++) begin
        bad = 0;
        for (int c = 0; c < CPB; c++)
          if (cap_tx[b*CPB+c] !== ex[b] || cap_busy[b*CPB+c] !== 1'b1) bad = 1;
        tests++;
        if (bad) begin
          fails++;
          $display("[TB] FAIL 7n1_bit%0d word=%h: tx=%b mid-bit, need %b held %0d cycles with busy",
                   b, w, cap_tx[b*CPB+CPB/2], ex[b], CPB);
        end
      end
      nb = 0;
      foreach (cap_busy[i]) nb += int'(cap_busy[i]);
      tests++;
      if (nb !== 144) begin
        fails++;
        $display("[TB] FAIL 7n1_busy_len word=%h: %0d cycles, need 144", w, nb);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [8:0] words [6];
    logic [15:0] ex;
    int pcs [6];
    int fl, fb, idx, need;
    bit okp [6];
    bit okc, bad, busy_gap;
    fb = frame_bits(8, PARITY_EVEN, 1);
    fl = fb * CPB;
    foreach (words[i]) words[i] = 9'($urandom_range(0, 255));
    fork
      begin
        for (int i = 0; i < 6; i++) push_word(0, words[i], pcs[i], okp[i]);
      end
      begin
        capture(0, 6 * fl, okc);
      end
    join
    tests++;
    if (!okc || !okp[5]) begin
      fails++;
      $display("[TB] FAIL b2b_timeout frame_seen=%b last_push_ok=%b, need 1 1", okc, okp[5]);
      return;
    end
    for (int i = 1; i < 5; i++) begin
      tests++;
      if (pcs[i] !== pcs[0] + i) begin
        fails++;
        $display("[TB] FAIL b2b_push%0d: accepted at edge %0d, need %0d", i, pcs[i], pcs[0] + i);
      end
    end
    idx = pcs[4] - fall_cycle;
    tests++;
    if (idx < 0 || cap_cnt[idx] !== 3'd4 || cap_rdy[idx] !== 1'b0) begin
      fails++;
      $display("[TB] FAIL b2b_full: count=%0d ready=%b after 5th push, need 4 0",
               (idx >= 0) ? cap_cnt[idx] : 3'd7, (idx >= 0) ? cap_rdy[idx] : 1'bx);
    end
    tests++;
    if (pcs[5] !== fall_cycle + fl + 1) begin
      fails++;
      $display("[TB] FAIL b2b_stalled_push: accepted at edge %0d, need %0d", pcs[5], fall_cycle + fl + 1);
    end
    busy_gap = 0;
    for (int f = 0; f < 6; f++) begin
      ex = model_frame(words[f], 8, PARITY_EVEN, 1);
      for (int b = 0; b < fb; b++) begin
        bad = 0;
        for (int c = 0; c < CPB; c++) begin
          if (cap_tx[f*fl+b*CPB+c] !== ex[b]) bad = 1;
          if (cap_busy[f*fl+b*CPB+c] !== 1'b1) busy_gap = 1;
        end
        tests++;
        if (bad) begin
          fails++;
          $display("[TB] FAIL b2b_frame%0d_bit%0d word=%h: tx=%b mid-bit, need %b",
                   f, b, words[f], cap_tx[f*fl+b*CPB+CPB/2], ex[b]);
        end
      end
      need = (f == 0) ? 4 : 5 - f;
      tests++;
      if (cap_cnt[f*fl+fl/2] !== 3'(need)) begin
        fails++;
        $display("[TB] FAIL b2b_count_frame%0d: count=%0d, need %0d", f, cap_cnt[f*fl+fl/2], need);
      end
    end
    tests++;
    if (busy_gap) begin
      fails++;
      $display("[TB] FAIL b2b_busy_gap: busy dropped between frames, need 1 throughout");
    end
    tests++;
    if (cap_tx[6*fl] !== 1'b1 || cap_busy[6*fl] !== 1'b0 || cap_cnt[6*fl] !== 3'd0) begin
      fails++;
      $display("[TB] FAIL b2b_end: tx=%b busy=%b count=%0d, need 1 0 0",
               cap_tx[6*fl], cap_busy[6*fl], cap_cnt[6*fl]);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [8:0] w;
    logic [15:0] ex;
    int pc, fb;
    bit okp, okc, bad, stray;
    fb = frame_bits(8, PARITY_EVEN, 1);
    push_word(0, 9'($urandom_range(0, 255)), pc, okp);
    push_word(0, 9'($urandom_range(0, 255)), pc, okp);
    capture(0, 3 * CPB + 5, okc);
    tests++;
    if (!okc) begin
      fails++;
      $display("[TB] FAIL midrst_no_frame: no start bit seen, need one");
    end
    #3 rst_n = 1'b0;
    #1;
    tests++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0 || if_a.s_ready !== 1'b1 || cnt_a !== 3'd0) begin
      fails++;
      $display("[TB] FAIL midrst_async: tx=%b busy=%b ready=%b count=%0d, need 1 0 1 0",
               tx_a, busy_a, if_a.s_ready, cnt_a);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || cnt_a !== 3'd0) stray = 1;
    end
    tests++;
    if (stray) begin
      fails++;
      $display("[TB] FAIL midrst_quiet: tx=%b busy=%b count=%0d seen after release, need 1 0 0",
               tx_a, busy_a, cnt_a);
    end
    w = 9'($urandom_range(0, 255));
    ex = model_frame(w, 8, PARITY_EVEN, 1);
    push_word(0, w, pc, okp);
    capture(0, fb * CPB, okc);
    tests++;
    if (!okp || !okc || fall_cycle - pc !== 2) begin
      fails++;
      $display("[TB] FAIL midrst_restart: push_ok=%b frame_seen=%b latency=%0d, need 1 1 2",
               okp, okc, fall_cycle - pc);
    end else begin
      bad = 0;
      for (int i = 0; i < fb * CPB; i++) if (cap_tx[i] !== ex[i/CPB]) bad = 1;
      tests++;
      if (bad) begin
        fails++;
        $display("[TB] FAIL midrst_frame word=%h: serial pattern wrong, need %b", w, ex);
      end
    end
  endtask

  // Scenario sequence
  initial begin
    set_valid(0, 1'b0, 9'h0);
    set_valid(1, 1'b0, 9'h0);
    set_valid(2, 1'b0, 9'h0);
    test_reset();
    test_8e1();
    test_odd_2stop();
    test_7n1();
    apply_reset();
    test_back_to_back();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
